sd_cmd_rx: RTL and testbench

SD_CMD_RX -- requirements
Module: sd_cmd_rx

---
 rtl/sd_defines.sv | 17 +
 rtl/sd_crc7.sv | 26 ++
 rtl/sd_cmd_rx.sv | 114 +++++++++++
 tb/tb_sd_cmd_rx.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/sd_defines.sv
// Shared constants and state encoding for the SD command-line receiver.
package sd_defines;

  localparam int FRAME_LEN    = 48;
  localparam int PAYLOAD_BITS = 38;
  localparam int CRC_W        = 7;
  localparam logic [CRC_W-1:0] CRC_POLY = 7'h09;

  typedef enum logic [2:0] {
    IDLE,
    TRANS,
    PAYLOAD,
    CRC,
    STOP
  } rx_state_t;

endpackage

// File: rtl/sd_crc7.sv
// Bit-serial CRC7 (x^7 + x^3 + 1) with synchronous clear and step enable.
module sd_crc7
  import sd_defines::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             clear,
  input  logic             bit_in,
  output logic [CRC_W-1:0] crc
);

  logic fb;
  assign fb = bit_in ^ crc[CRC_W-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= '0;
    end else if (clear) begin
      crc <= '0;
    end else if (enable) begin
      crc <= {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
    end
  end

endmodule

// File: rtl/sd_cmd_rx.sv
// SD CMD-line frame receiver: deserialises 48-bit host commands sampled on
// SAMPLE_EN, checks framing and CRC7, and reports one status pulse per frame.
module sd_cmd_rx
  import sd_defines::*;
#(
  parameter int CRC_CHECK = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        SAMPLE_EN,
  input  logic        CMD_IN,
  output logic [5:0]  CMD_INDEX,
  output logic [31:0] CMD_ARG,
  output logic        CMD_VALID,
  output logic        CRC_ERR,
  output logic        FRAME_ERR,
  output logic        BUSY
);

  localparam logic [5:0] PAY_LAST = 6'(PAYLOAD_BITS - 1);
  localparam logic [5:0] CRC_LAST = 6'(CRC_W - 1);

  rx_state_t                state;
  logic [5:0]               bit_cnt;
  logic [PAYLOAD_BITS-1:0]  payload;
  logic [CRC_W-1:0]         crc_rx;
  logic [CRC_W-1:0]         crc_calc;
  logic                     crc_en;
  logic                     crc_clr;

  // The start bit is 0 and the CRC seed is 0, so feeding it would not change
  // the CRC; accumulation starts with the transmission bit.
  assign crc_clr = (state == IDLE);
  assign crc_en  = SAMPLE_EN && ((state == TRANS) || (state == PAYLOAD));
  assign BUSY    = (state != IDLE);

  sd_crc7 u_crc7 (
    .clk    (CLK),
    .rst    (RST),
    .enable (crc_en),
    .clear  (crc_clr),
    .bit_in (CMD_IN),
    .crc    (crc_calc)
  );

  always_ff @(posedge CLK) begin
    if (SAMPLE_EN) begin
      if (state == PAYLOAD) payload <= {payload[PAYLOAD_BITS-2:0], CMD_IN};
      if (state == CRC)     crc_rx  <= {crc_rx[CRC_W-2:0], CMD_IN};
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      CMD_INDEX <= '0;
      CMD_ARG   <= '0;
      CMD_VALID <= 1'b0;
      CRC_ERR   <= 1'b0;
      FRAME_ERR <= 1'b0;
    end else begin
      CMD_VALID <= 1'b0;
      CRC_ERR   <= 1'b0;
      FRAME_ERR <= 1'b0;
      if (SAMPLE_EN) begin
        case (state)
          IDLE: begin
            if (!CMD_IN) state <= TRANS;
          end
          TRANS: begin
            bit_cnt <= '0;
            if (CMD_IN) begin
              state <= PAYLOAD;
            end else begin
              FRAME_ERR <= 1'b1;
              state     <= IDLE;
            end
          end
          PAYLOAD: begin
            if (bit_cnt == PAY_LAST) begin
              bit_cnt <= '0;
              state   <= CRC;
            end else begin
              bit_cnt <= bit_cnt + 6'd1;
            end
          end
          CRC: begin
            if (bit_cnt == CRC_LAST) begin
              bit_cnt <= '0;
              state   <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 6'd1;
            end
          end
          STOP: begin
            state <= IDLE;
            if (!CMD_IN) begin
              FRAME_ERR <= 1'b1;
            end else if ((CRC_CHECK != 0) && (crc_rx != crc_calc)) begin
              CRC_ERR <= 1'b1;
            end else begin
              CMD_VALID <= 1'b1;
              CMD_INDEX <= payload[PAYLOAD_BITS-1:32];
              CMD_ARG   <= payload[31:0];
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sd_cmd_rx.sv
// Scoreboard bench for sd_cmd_rx: two instances (CRC checked / ignored) share
// the stimulus; expected outcomes come from a polynomial-division reference.
module tb_sd_cmd_rx;
  import sd_defines::*;

  typedef struct {
    int          kind;   // 0 valid, 1 crc error, 2 frame error
    logic [5:0]  idx;
    logic [31:0] arg;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        SAMPLE_EN = 1'b0;
  logic        CMD_IN = 1'b1;
  logic [5:0]  idx0, idx1;
  logic [31:0] arg0, arg1;
  logic        v0, c0, f0, b0, v1, c1, f1, b1;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  exp_t q0[$];
  exp_t q1[$];
  int   stamps[$];
  logic [5:0]  last_idx[2];
  logic [31:0] last_arg[2];

  sd_cmd_rx #(.CRC_CHECK(1)) dut (
    .CLK(CLK), .RST(RST), .SAMPLE_EN(SAMPLE_EN), .CMD_IN(CMD_IN),
    .CMD_INDEX(idx0), .CMD_ARG(arg0), .CMD_VALID(v0), .CRC_ERR(c0),
    .FRAME_ERR(f0), .BUSY(b0)
  );

  sd_cmd_rx #(.CRC_CHECK(0)) dut_nc (
    .CLK(CLK), .RST(RST), .SAMPLE_EN(SAMPLE_EN), .CMD_IN(CMD_IN),
    .CMD_INDEX(idx1), .CMD_ARG(arg1), .CMD_VALID(v1), .CRC_ERR(c1),
    .FRAME_ERR(f1), .BUSY(b1)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Remainder of M(x)*x^7 divided by x^7+x^3+1 (long division).
  function automatic logic [6:0] crc7_ref(input logic [39:0] m);
    logic [46:0] r;
    r = {m, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  function automatic logic [47:0] mk_frame(input logic [5:0] idx, input logic [31:0] arg);
    return {2'b01, idx, arg, crc7_ref({2'b01, idx, arg}), 1'b1};
  endfunction

  function automatic exp_t model(input int inst, input logic [47:0] f);
    exp_t e;
    if (!f[46] || !f[0]) e.kind = 2;
    else if (inst == 0 && f[7:1] != crc7_ref(f[47:8])) e.kind = 1;
    else e.kind = 0;
    if (e.kind == 0) begin
      last_idx[inst] = f[45:40];
      last_arg[inst] = f[39:8];
    end
    e.idx = last_idx[inst];
    e.arg = last_arg[inst];
    return e;
  endfunction

  task automatic send_bits(input logic [47:0] f, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      repeat (gap) begin
        @(negedge CLK);
        SAMPLE_EN = 1'b0;
        CMD_IN = 1'($urandom);
      end
      @(negedge CLK);
      SAMPLE_EN = 1'b1;
      CMD_IN = f[FRAME_LEN-1-i];
    end
  endtask

  task automatic run_frame(input logic [47:0] f, input int n, input int gap);
    q0.push_back(model(0, f));
    q1.push_back(model(1, f));
    send_bits(f, n, gap);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      SAMPLE_EN = 1'b0;
      CMD_IN = 1'b1;
    end
  endtask

  task automatic check_pulse(input int inst, input logic v, input logic c, input logic f,
                             input logic busy, input logic [5:0] idx, input logic [31:0] arg);
    exp_t e;
    int   got;
    chk($sformatf("onehot%0d", inst), 64'(int'(v) + int'(c) + int'(f)), 64'd1);
    chk($sformatf("busy_after%0d", inst), 64'(busy), 64'd0);
    if (inst == 0 && v) stamps.push_back(cyc);
    if ((inst == 0 && q0.size() == 0) || (inst == 1 && q1.size() == 0)) begin
      chk($sformatf("unexpected_pulse%0d", inst), 64'd1, 64'd0);
    end else begin
      e = (inst == 0) ? q0.pop_front() : q1.pop_front();
      got = v ? 0 : (c ? 1 : 2);
      chk($sformatf("status%0d", inst), 64'(got), 64'(e.kind));
      chk($sformatf("index%0d", inst), 64'(idx), 64'(e.idx));
      chk($sformatf("arg%0d", inst), 64'(arg), 64'(e.arg));
    end
  endtask

  always @(negedge CLK) begin
    if (!RST) begin
      if (v0 | c0 | f0) check_pulse(0, v0, c0, f0, b0, idx0, arg0);
      if (v1 | c1 | f1) check_pulse(1, v1, c1, f1, b1, idx1, arg1);
    end
  end

  task automatic check_reset_state(input string tag);
    chk({tag, "_index"}, 64'(idx0), 64'd0);
    chk({tag, "_arg"}, 64'(arg0), 64'd0);
    chk({tag, "_pulses"}, 64'({v0, c0, f0}), 64'd0);
    chk({tag, "_busy"}, 64'(b0), 64'd0);
    chk({tag, "_nc_all"}, 64'({idx1, arg1, v1, c1, f1, b1}), 64'd0);
  endtask

  initial begin
    logic [47:0] f;
    int          sel;
    last_idx[0] = '0; last_idx[1] = '0;
    last_arg[0] = '0; last_arg[1] = '0;

    repeat (3) @(negedge CLK);
    check_reset_state("reset");
    RST = 1'b0;
    idle(2);

    run_frame(48'h40_0000_0000_95, FRAME_LEN, 0);   // CMD0
    idle(3);
    run_frame(48'h48_0000_01AA_87, FRAME_LEN, 3);   // CMD8, 3 idle CLKs per sample
    idle(3);
    run_frame(48'h51_0000_0000_57, FRAME_LEN, 1);   // CMD17, CRC bit 0 flipped
    idle(3);
    run_frame(48'h00_0000_0000_00, 2, 0);           // transmission bit 0
    idle(3);
    run_frame(48'h40_0000_0000_94, FRAME_LEN, 0);   // CMD0, end bit 0
    idle(3);

    send_bits(48'h40_0000_0000_95, 20, 0);
    @(negedge CLK);
    SAMPLE_EN = 1'b0;
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    check_reset_state("midreset");
    last_idx[0] = '0; last_idx[1] = '0;
    last_arg[0] = '0; last_arg[1] = '0;
    RST = 1'b0;
    idle(2);
    stamps.delete();
    run_frame(48'h48_0000_01AA_87, FRAME_LEN, 0);
    idle(3);
    chk("reset_then_cmd8_count", 64'(stamps.size()), 64'd1);

    stamps.delete();
    run_frame(48'h40_0000_0000_95, FRAME_LEN, 0);
    run_frame(48'h48_0000_01AA_87, FRAME_LEN, 0);
    idle(4);
    chk("b2b_count", 64'(stamps.size()), 64'd2);
    if (stamps.size() == 2) chk("b2b_spacing", 64'(stamps[1] - stamps[0]), 64'd48);

    for (int k = 0; k < 25; k++) begin
      f = mk_frame(6'($urandom), $urandom);
      sel = $urandom_range(0, 9);
      if (sel == 0) f[7:1] = f[7:1] ^ 7'($urandom_range(1, 127));
      else if (sel == 1) f[0] = 1'b0;
      if (sel == 2) begin
        f[46] = 1'b0;
        run_frame(f, 2, $urandom_range(0, 3));
      end else begin
        run_frame(f, FRAME_LEN, $urandom_range(0, 3));
      end
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(2);

    for (int t = 0; t < 20 && (q0.size() != 0 || q1.size() != 0); t++) @(negedge CLK);
    chk("drain_q0", 64'(q0.size()), 64'd0);
    chk("drain_q1", 64'(q1.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
